// File: rtl/ahb_fifo_tx_slave.sv
// ============================================================================
// ahb_fifo_tx_slave
//
// Bus slave that accepts master writes into a DEPTH-entry FIFO and drains the
// FIFO through a valid/ready stream toward a downstream consumer (UART, LED
// shifter, ...). Software polls fill level and the sticky overflow flag via
// STATUS, and enables/flushes the stream via CTRL.
//
// Register map (HADDR_bi[3:2]):
//   0 DATA   W: push HWDATA_bi[DATA_W-1:0]  R: head word (no pop), 0 if empty
//   1 STATUS R: {count[15:8], irq[3], overflow[2], full[1], empty[0]}
//            W: bit2 = 1 clears overflow
//   2 CTRL   bit0 EN, bit1 FLUSH (self-clearing, reads 0), bit2 IRQ_EN
//   3 reserved, reads 0
//
// Ports:
//   HCLK_i     clock, rising edge
//   HRESETn_i  asynchronous active-low reset
//   HSEL_i     transfer valid for this slave this cycle
//   HADDR_bi   byte address, only [3:2] decoded
//   HWDATA_bi  write data, same cycle as address
//   HWRITE_i   1 = write, 0 = read
//   HRDATA_bo  registered read data, valid the cycle after a read, else 0
//   m_valid_o  stream word available (EN & ~empty)
//   m_data_o   stream word (FIFO head), 0 when empty
//   m_ready_i  consumer accepts word
//   irq_o      (only with AHB_FIFO_TX_SLAVE_IRQ_EN) registered interrupt
//
// Optional feature macro: AHB_FIFO_TX_SLAVE_IRQ_EN
//   Adds irq_o, CTRL.IRQ_EN and STATUS.irq. irq_o goes high the cycle after
//   IRQ_EN & ((count <= LOW_WM) | overflow) becomes true.
// ============================================================================
module ahb_fifo_tx_slave #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int LOW_WM = 2
) (
    input  logic              HCLK_i,
    input  logic              HRESETn_i,
    input  logic              HSEL_i,
    input  logic [31:0]       HADDR_bi,
    input  logic [31:0]       HWDATA_bi,
    input  logic              HWRITE_i,
    output logic [31:0]       HRDATA_bo,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i
`ifdef AHB_FIFO_TX_SLAVE_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              en_q,     en_d;
    logic              ovf_q,    ovf_d;
    logic [31:0]       hrdata_q, hrdata_d;

    // ------------------------------------------------------------------------
    // Transfer decode
    // ------------------------------------------------------------------------
    logic [1:0] reg_addr;
    logic       bus_wr, bus_rd;
    logic       push_req, push, pop, flush, ovf_set, ovf_clr, ctrl_wr;
    logic       empty, full;
    logic       irq_bit;
    logic [DATA_W-1:0] head;

    // Address bits outside [3:2] are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{HADDR_bi[31:4], HADDR_bi[1:0], HWDATA_bi};

    assign reg_addr = HADDR_bi[3:2];
    assign bus_wr   = HSEL_i &  HWRITE_i;
    assign bus_rd   = HSEL_i & ~HWRITE_i;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Show-ahead head word; forced to 0 so stale storage never leaks out.
    assign head = empty ? '0 : mem_q[rd_ptr_q];

    // Stream outputs depend only on registered state, never on m_ready_i.
    assign m_valid_o = en_q & ~empty;
    assign m_data_o  = head;

    assign pop      = m_valid_o & m_ready_i;
    assign push_req = bus_wr & (reg_addr == ADDR_DATA);
    // A full FIFO still accepts a push when a pop frees a slot this edge.
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;
    assign ovf_clr  = bus_wr & (reg_addr == ADDR_STATUS) & HWDATA_bi[2];
    assign ctrl_wr  = bus_wr & (reg_addr == ADDR_CTRL);
    assign flush    = ctrl_wr & HWDATA_bi[1];

    // ------------------------------------------------------------------------
    // Optional interrupt
    // ------------------------------------------------------------------------
`ifdef AHB_FIFO_TX_SLAVE_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q,    irq_d;

    assign irq_en_d = ctrl_wr ? HWDATA_bi[2] : irq_en_q;
    assign irq_d    = irq_en_q & ((32'(count_q) <= 32'(LOW_WM)) | ovf_q);
    assign irq_bit  = irq_q;
    assign irq_o    = irq_q;

    always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
        if (!HRESETn_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign irq_bit = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        en_d     = en_q;
        ovf_d    = ovf_q;

        if (flush) begin
            // A pop coinciding with the flush is discarded with the contents.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (ctrl_wr) en_d = HWDATA_bi[0];

        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    // Read data is captured in the transfer cycle and is 0 in every other one.
    always_comb begin
        hrdata_d = '0;
        if (bus_rd) begin
            case (reg_addr)
                ADDR_DATA:   hrdata_d[DATA_W-1:0] = head;
                ADDR_STATUS: begin
                    hrdata_d[0]          = empty;
                    hrdata_d[1]          = full;
                    hrdata_d[2]          = ovf_q;
                    hrdata_d[3]          = irq_bit;
                    hrdata_d[8 +: CNT_W] = count_q;
                end
                ADDR_CTRL: begin
                    hrdata_d[0] = en_q;
`ifdef AHB_FIFO_TX_SLAVE_IRQ_EN
                    hrdata_d[2] = irq_en_q;
`endif
                end
                default:     hrdata_d = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
        if (!HRESETn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
            ovf_q    <= 1'b0;
            hrdata_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
            hrdata_q <= hrdata_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the count gates every
    // read of it, so its power-up contents are never observable.
    always_ff @(posedge HCLK_i) begin
        if (push) mem_q[wr_ptr_q] <= HWDATA_bi[DATA_W-1:0];
    end

    assign HRDATA_bo = hrdata_q;

endmodule

// File: tb/tb_ahb_fifo_tx_slave.sv
// ============================================================================
// tb_ahb_fifo_tx_slave
//
// Directed bench for ahb_fifo_tx_slave with DEPTH=4, DATA_W=8. Inputs are
// driven on the falling edge and outputs sampled on the falling edge, so the
// DUT always sees stable inputs at the rising edge.
// ============================================================================
module tb_ahb_fifo_tx_slave;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hsel;
    logic [31:0]       haddr;
    logic [31:0]       hwdata;
    logic              hwrite;
    logic [31:0]       hrdata;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    int checks   = 0;
    int failures = 0;

    ahb_fifo_tx_slave #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LOW_WM (2)
    ) dut (
        .HCLK_i    (clk),
        .HRESETn_i (rst_n),
        .HSEL_i    (hsel),
        .HADDR_bi  (haddr),
        .HWDATA_bi (hwdata),
        .HWRITE_i  (hwrite),
        .HRDATA_bo (hrdata),
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .m_ready_i (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One write transfer; called and returns at a falling edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        hsel   = 1'b1;
        hwrite = 1'b1;
        haddr  = addr;
        hwdata = data;
        @(negedge clk);
        hsel   = 1'b0;
        hwrite = 1'b0;
    endtask

    // One read transfer; on return HRDATA_bo holds the result.
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        hsel   = 1'b1;
        hwrite = 1'b0;
        haddr  = addr;
        @(negedge clk);
        hsel   = 1'b0;
        data   = hrdata;
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  exp_stream [4];

        rst_n   = 1'b0;
        hsel    = 1'b0;
        haddr   = '0;
        hwdata  = '0;
        hwrite  = 1'b0;
        m_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_hrdata",  hrdata,  32'h0);
        check("reset_m_valid", 32'(m_valid), 32'h0);
        check("reset_m_data",  32'(m_data),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(A_STATUS, rd);
        check("reset_status", rd, 32'h0000_0001);

        // Fill past capacity with EN=0: fifth write dropped, overflow set
        bus_write(A_DATA, 32'h11);
        bus_write(A_DATA, 32'h22);
        bus_write(A_DATA, 32'h33);
        bus_write(A_DATA, 32'h44);
        bus_write(A_DATA, 32'h55);
        bus_read(A_STATUS, rd);
        check("overflow_status", rd, 32'h0000_0406);
        check("en0_m_valid", 32'(m_valid), 32'h0);
        check("en0_m_data",  32'(m_data),  32'h11);
        bus_read(A_DATA, rd);
        check("data_read_head", rd, 32'h11);
        @(negedge clk);
        check("hrdata_idle_zero", hrdata, 32'h0);
        bus_read(A_CTRL, rd);
        check("ctrl_reset_read", rd, 32'h0);

        // Clear overflow (W1C)
        bus_write(A_STATUS, 32'h4);
        bus_read(A_STATUS, rd);
        check("ovf_cleared_status", rd, 32'h0000_0402);

        // Enable with ready high: stream drains on consecutive cycles
        m_ready = 1'b1;
        bus_write(A_CTRL, 32'h1);
        exp_stream = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stream_valid_%0d", i), 32'(m_valid), 32'h1);
            check($sformatf("stream_data_%0d", i),  32'(m_data),  32'(exp_stream[i]));
            @(negedge clk);
        end
        check("drained_m_valid", 32'(m_valid), 32'h0);
        check("drained_m_data",  32'(m_data),  32'h0);
        bus_read(A_STATUS, rd);
        check("drained_status", rd, 32'h0000_0001);

        // Full FIFO with a simultaneous pop: push accepted, no overflow
        m_ready = 1'b0;
        bus_write(A_DATA, 32'hA1);
        bus_write(A_DATA, 32'hA2);
        bus_write(A_DATA, 32'hA3);
        bus_write(A_DATA, 32'hA4);
        m_ready = 1'b1;
        bus_write(A_DATA, 32'h66);
        m_ready = 1'b0;
        bus_read(A_STATUS, rd);
        check("full_pushpop_status", rd, 32'h0000_0402);
        m_ready = 1'b1;
        exp_stream = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_stream_%0d", i), 32'(m_data), 32'(exp_stream[i]));
            @(negedge clk);
        end
        check("full_stream_end_valid", 32'(m_valid), 32'h0);
        m_ready = 1'b0;

        // Ready toggling: one pop per high cycle, data held while low
        bus_write(A_DATA, 32'hB1);
        bus_write(A_DATA, 32'hB2);
        bus_write(A_DATA, 32'hB3);
        check("toggle_head", 32'(m_data), 32'hB1);
        m_ready = 1'b1;
        @(negedge clk);
        check("toggle_pop1", 32'(m_data), 32'hB2);
        m_ready = 1'b0;
        @(negedge clk);
        check("toggle_hold1", 32'(m_data), 32'hB2);
        m_ready = 1'b1;
        @(negedge clk);
        check("toggle_pop2", 32'(m_data), 32'hB3);
        m_ready = 1'b0;
        @(negedge clk);
        check("toggle_hold2", 32'(m_data), 32'hB3);
        bus_read(A_STATUS, rd);
        check("toggle_status", rd, 32'h0000_0100);

        // Flush with EN kept on
        bus_write(A_DATA, 32'hC1);
        bus_write(A_DATA, 32'hC2);
        bus_write(A_CTRL, 32'h3);
        check("flush_m_valid", 32'(m_valid), 32'h0);
        check("flush_m_data",  32'(m_data),  32'h0);
        bus_read(A_STATUS, rd);
        check("flush_status", rd, 32'h0000_0001);
        bus_read(A_CTRL, rd);
        check("flush_ctrl_read", rd, 32'h0000_0001);
        bus_write(A_DATA, 32'h77);
        check("post_flush_valid", 32'(m_valid), 32'h1);
        check("post_flush_data",  32'(m_data),  32'h77);

        // Reserved register
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        bus_read(A_RSVD, rd);
        check("reserved_read", rd, 32'h0);

        // Asynchronous reset between edges, with a read just captured
        bus_write(A_DATA, 32'hD2);
        hsel    = 1'b1;
        hwrite  = 1'b0;
        haddr   = A_DATA;
        m_ready = 1'b1;
        @(posedge clk);
        #2;
        check("pre_reset_hrdata", hrdata, 32'h77);
        check("pre_reset_m_data", 32'(m_data), 32'hD2);
        rst_n = 1'b0;
        #1;
        check("async_rst_hrdata",  hrdata, 32'h0);
        check("async_rst_m_valid", 32'(m_valid), 32'h0);
        check("async_rst_m_data",  32'(m_data),  32'h0);
        @(negedge clk);
        hsel    = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        bus_read(A_STATUS, rd);
        check("post_reset_status", rd, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
